// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the icache/dcache memory arbiter.
// Latency and backpressure are not applicable: this file holds declarations only.
package arb_pkg;

    localparam int ARB_ADDR_W = 6;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    // Tie-break pointer values: which requester wins when both ask at once.
    localparam logic PTR_DCACHE = 1'b0;
    localparam logic PTR_ICACHE = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-way chooser between icache and dcache requests; purely combinational, zero latency.
// No backpressure: the caller only uses the result when at least one side is requesting.
module arb_pick
    import arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic ptr,
    output logic o_grant_d
);

    // The dcache wins unless the icache is also asking and the pointer favours it.
    assign o_grant_d = d_req && !(i_req && (ptr == PTR_ICACHE));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache fills and dcache fills/write-backs onto one memory port; grant 1 cycle after request, done when memory drops busywait.
// Requesters are stalled through x_busywait; define ARB_ROUND_ROBIN_EN for an alternating tie-break instead of dcache priority.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readData,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writeData,
    output logic [DATA_W-1:0] d_readData,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData,
    input  logic              mem_busywait
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_first;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_d_req;
    logic w_d_wr;
    logic w_d_rd;
    logic w_complete;
    logic w_i_done;
    logic w_d_done;
    logic w_d_fill;
    logic w_pick_d;
    logic w_ptr;

    // A simultaneous read and write from the dcache is treated as a write.
    assign w_d_req = d_read | d_write;
    assign w_d_wr  = d_write;
    assign w_d_rd  = d_read & ~d_write;

    // r_first hides the entry cycle, before memory has been able to raise busywait.
    assign w_complete = (r_state != ARB_IDLE) && !r_first && !mem_busywait;
    assign w_i_done   = (r_state == ARB_GRANT_I) && w_complete && i_read;
    assign w_d_done   = (r_state == ARB_GRANT_D) && w_complete && w_d_req;
    assign w_d_fill   = w_d_done && w_d_rd;

    arb_pick u_pick (
        .i_req     (i_read),
        .d_req     (w_d_req),
        .ptr       (w_ptr),
        .o_grant_d (w_pick_d)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = PTR_DCACHE;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_d_req || i_read) begin
                    w_next = w_pick_d ? ARB_GRANT_D : ARB_GRANT_I;
                end
            end
            ARB_GRANT_I: begin
                if (!i_read || w_complete) begin
                    w_next = ARB_IDLE;
                end
            end
            ARB_GRANT_D: begin
                if (!w_d_req || w_complete) begin
                    w_next = ARB_IDLE;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ARB_IDLE;
            r_first   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr     <= PTR_DCACHE;
`endif
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
            if (w_i_done) begin
                r_i_rdata <= mem_readData;
            end
            if (w_d_fill) begin
                r_d_rdata <= mem_readData;
            end
`ifdef ARB_ROUND_ROBIN_EN
            // Aborted grants leave the pointer where it was.
            if (w_i_done) begin
                r_ptr <= PTR_DCACHE;
            end else if (w_d_done) begin
                r_ptr <= PTR_ICACHE;
            end
`endif
        end
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        case (r_state)
            ARB_GRANT_I: begin
                mem_read    = i_read;
                mem_address = i_address;
            end
            ARB_GRANT_D: begin
                mem_read      = w_d_rd;
                mem_write     = w_d_wr;
                mem_address   = d_address;
                mem_writeData = d_writeData;
            end
            default: ;
        endcase
    end

    // Held in reset, neither cache is told to stall.
    assign i_busywait = reset && i_read && !w_i_done;
    assign d_busywait = reset && w_d_req && !w_d_done;

    // Fill data is forwarded in the completion cycle so the cache can use it at once.
    assign i_readData = w_i_done ? mem_readData : r_i_rdata;
    assign d_readData = w_d_fill ? mem_readData : r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter against a behavioural latency-programmable memory,
// with a scoreboard of expected memory transactions.
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [5:0]  i_address = '0;
    logic [31:0] i_readData;
    logic        i_busywait;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [5:0]  d_address = '0;
    logic [31:0] d_writeData = '0;
    logic [31:0] d_readData;
    logic        d_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;
    logic        mem_busywait;

    int tests_run = 0;
    int tests_failed = 0;
    int mem_lat = 5;

    txn_t exp_q[$];
    txn_t obs_q[$];

    mem_arbiter dut (
        .clock         (clk),
        .reset         (rst_n),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readData    (i_readData),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writeData   (d_writeData),
        .d_readData    (d_readData),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData),
        .mem_busywait  (mem_busywait)
    );

    always #5 clk = ~clk;

    function automatic txn_t mk(input logic is_d, input logic wr, input logic [5:0] a, input logic [31:0] dat);
        txn_t t;
        t.is_d = is_d;
        t.wr   = wr;
        t.addr = a;
        t.data = dat;
        return t;
    endfunction

    function automatic logic [31:0] mem_init(input logic [5:0] a);
        if (a == 6'h0A) return 32'hDEADBEEF;
        return 32'hC0DE0000 | {26'd0, a};
    endfunction

    // Behavioural memory: busywait rises the edge after a strobe appears, stays high
    // mem_lat cycles, then drops for one cycle with the data valid.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_rd = '0;
    logic [31:0] m_wr_data [0:63];
    bit          m_wr_vld [0:63];

    assign mem_busywait = m_busy;
    assign mem_readData = m_rd;

    always @(posedge clk) begin
        if (!mem_read && !mem_write) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= mem_lat;
        end else if (m_cnt == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            if (mem_write) begin
                m_wr_data[mem_address] <= mem_writeData;
                m_wr_vld[mem_address]  <= 1'b1;
            end else begin
                m_rd <= m_wr_vld[mem_address] ? m_wr_data[mem_address] : mem_init(mem_address);
            end
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    // Record every transaction memory completes, tagged with the cache that saw it finish.
    always @(negedge clk) begin
        if (rst_n && m_done && (mem_read || mem_write)) begin
            obs_q.push_back(mk((d_read || d_write) && !d_busywait, mem_write, mem_address,
                               mem_write ? mem_writeData : mem_readData));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic req_i(input logic [5:0] addr, output int busy_cyc, output logic [31:0] rdata,
                         output logic busy_after, output logic strobe_after, output logic ok);
        i_address = addr;
        i_read    = 1'b1;
        busy_cyc  = 0;
        ok        = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!i_busywait) begin
                ok = 1'b1;
                break;
            end
            busy_cyc++;
        end
        @(posedge clk);
        #1;
        rdata        = i_readData;
        busy_after   = i_busywait;
        strobe_after = mem_read | mem_write;
        i_read       = 1'b0;
    endtask

    task automatic req_d(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                         output int busy_cyc, output logic [31:0] rdata, output logic ok);
        d_address   = addr;
        d_writeData = wdata;
        d_write     = wr;
        d_read      = !wr;
        busy_cyc    = 0;
        ok          = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!d_busywait) begin
                ok = 1'b1;
                break;
            end
            busy_cyc++;
        end
        @(posedge clk);
        #1;
        rdata   = d_readData;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic test_reset();
        logic ok;
        d_address = 6'h21;
        d_read    = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (d_busywait !== 1'b0) begin tests_failed++; $display("FAIL reset_d_busywait: got %b want 0", d_busywait); end
        tests_run++;
        if ({mem_read, mem_write} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
        tests_run++;
        if ({mem_address, mem_writeData, i_readData, d_readData} !== '0) begin
            tests_failed++;
            $display("FAIL reset_buses: addr %h wdata %h ird %h drd %h want all 0", mem_address, mem_writeData, i_readData, d_readData);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 6'h21, mem_init(6'h21)));
        mem_lat = 2;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_read, mem_address} !== {1'b1, 6'h21}) begin
            tests_failed++;
            $display("FAIL reset_release_grant: got read %b addr %h want 1 21", mem_read, mem_address);
        end
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!d_busywait) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        d_read = 1'b0;
        tests_run++;
        if (!ok || d_readData !== mem_init(6'h21)) begin
            tests_failed++;
            $display("FAIL reset_first_fill: done %b data %h want 1 %h", ok, d_readData, mem_init(6'h21));
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL reset_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            txn_t e = exp_q.pop_front();
            txn_t o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL reset_sb_txn: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_icache_read();
        int busy;
        logic [31:0] rd;
        logic busy_after, strobe_after, ok;
        mem_lat = 5;
        @(negedge clk);
        exp_q.push_back(mk(1'b0, 1'b0, 6'h0A, 32'hDEADBEEF));
        req_i(6'h0A, busy, rd, busy_after, strobe_after, ok);
        tests_run++;
        if (!ok || busy != mem_lat + 1) begin tests_failed++; $display("FAIL icache_busy_cycles: done %b got %0d want %0d", ok, busy, mem_lat + 1); end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL icache_data: got %h want deadbeef", rd); end
        tests_run++;
        if (busy_after !== 1'b1) begin tests_failed++; $display("FAIL icache_busy_one_cycle: got %b want 1 after completion", busy_after); end
        tests_run++;
        if (strobe_after !== 1'b0) begin tests_failed++; $display("FAIL icache_back_to_idle: strobe %b want 0", strobe_after); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL icache_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            txn_t e = exp_q.pop_front();
            txn_t o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL icache_sb_txn: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_priority();
        int bi, bd;
        logic [31:0] ri, rd;
        logic ba, sa, oki, okd;
        mem_lat = 3;
        @(negedge clk);
        exp_q.push_back(mk(1'b1, 1'b1, 6'h15, 32'h12345678));
        exp_q.push_back(mk(1'b0, 1'b0, 6'h0A, 32'hDEADBEEF));
        fork
            req_d(1'b1, 6'h15, 32'h12345678, bd, rd, okd);
            req_i(6'h0A, bi, ri, ba, sa, oki);
        join
        tests_run++;
        if (!okd || bd != mem_lat + 1) begin tests_failed++; $display("FAIL prio_d_busy: done %b got %0d want %0d", okd, bd, mem_lat + 1); end
        tests_run++;
        if (!oki || bi != 2 * mem_lat + 4) begin tests_failed++; $display("FAIL prio_i_busy: done %b got %0d want %0d", oki, bi, 2 * mem_lat + 4); end
        tests_run++;
        if (ri !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL prio_i_data: got %h want deadbeef", ri); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL prio_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            txn_t e = exp_q.pop_front();
            txn_t o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL prio_sb_txn: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        mem_lat = 8;
        @(negedge clk);
        d_address = 6'h05;
        d_read    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_read, mem_write} !== 2'b00) begin tests_failed++; $display("FAIL rstmid_strobes: got %b want 00", {mem_read, mem_write}); end
        tests_run++;
        if (d_readData !== 32'h0) begin tests_failed++; $display("FAIL rstmid_data: got %h want 0", d_readData); end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (d_busywait !== 1'b1) begin tests_failed++; $display("FAIL rstmid_no_done: busywait %b want 1", d_busywait); end
        d_read = 1'b0;
        repeat (12) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0 || d_readData !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_abandoned: completions %0d data %h want 0 0", obs_q.size(), d_readData);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int bi, bd0, bd1;
        logic [31:0] ri, rd0, rd1;
        logic ba, sa, oki, okd0, okd1;
        mem_lat = 2;
        @(negedge clk);
        exp_q.push_back(mk(1'b1, 1'b1, 6'h30, 32'hA5A55A5A));
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(mk(1'b0, 1'b0, 6'h0A, 32'hDEADBEEF));
        exp_q.push_back(mk(1'b1, 1'b0, 6'h15, 32'h12345678));
`else
        exp_q.push_back(mk(1'b1, 1'b0, 6'h15, 32'h12345678));
        exp_q.push_back(mk(1'b0, 1'b0, 6'h0A, 32'hDEADBEEF));
`endif
        fork
            begin
                req_d(1'b1, 6'h30, 32'hA5A55A5A, bd0, rd0, okd0);
                req_d(1'b0, 6'h15, 32'h0, bd1, rd1, okd1);
            end
            req_i(6'h0A, bi, ri, ba, sa, oki);
        join
        tests_run++;
        if (!(okd0 && okd1 && oki)) begin tests_failed++; $display("FAIL b2b_done: d_wr %b d_rd %b i %b want 111", okd0, okd1, oki); end
        tests_run++;
        if (rd1 !== 32'h12345678) begin tests_failed++; $display("FAIL b2b_d_data: got %h want 12345678", rd1); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            txn_t e = exp_q.pop_front();
            txn_t o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL b2b_sb_txn: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_abort();
        logic ok;
        mem_lat = 6;
        @(negedge clk);
        d_address = 6'h22;
        d_read    = 1'b1;
        @(negedge clk);
        i_address = 6'h0B;
        i_read    = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 6'h0B, mem_init(6'h0B)));
        repeat (2) @(negedge clk);
        d_read = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_read, mem_write, mem_address, i_busywait} !== {1'b0, 1'b0, 6'h00, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_idle: rd %b wr %b addr %h ibusy %b want 0 0 00 1", mem_read, mem_write, mem_address, i_busywait);
        end
        @(negedge clk);
        tests_run++;
        if ({mem_read, mem_address} !== {1'b1, 6'h0B}) begin
            tests_failed++;
            $display("FAIL abort_regrant_i: rd %b addr %h want 1 0b", mem_read, mem_address);
        end
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!i_busywait) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_read = 1'b0;
        tests_run++;
        if (!ok || i_readData !== mem_init(6'h0B)) begin
            tests_failed++;
            $display("FAIL abort_i_data: done %b got %h want %h", ok, i_readData, mem_init(6'h0B));
        end
        tests_run++;
        if (d_readData !== 32'h12345678) begin tests_failed++; $display("FAIL abort_d_hold: got %h want 12345678", d_readData); end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL abort_sb_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            txn_t e = exp_q.pop_front();
            txn_t o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL abort_sb_txn: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_abort();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
